// File: rtl/simple_proc_ctrl.sv
// rtl/simple_proc_ctrl.sv - mv/mvi/add/sub sequencer driving the R0..R3/A/G/IR register loads and shared bus
// Optional status flags on the G load are enabled by defining PROC_CTRL_FLAGS_EN.
module simple_proc_ctrl #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  input  logic [n-1:0] din,
  output logic [n-1:0] bus,
  output logic         done,
  input  logic [1:0]   dbg_sel,
  output logic [n-1:0] dbg_q
`ifdef PROC_CTRL_FLAGS_EN
  ,
  output logic         zero_flag,
  output logic         carry_flag
`endif
);

  typedef enum logic [1:0] {T0, T1, T2, T3} state_t;

  localparam logic [1:0] OP_MV  = 2'b00;
  localparam logic [1:0] OP_MVI = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b11;

  state_t       state, state_nxt;
  logic [n-1:0] r [4];
  logic [n-1:0] a, g, alu;
  logic [5:0]   ir;
  logic [1:0]   op, x, y;
  logic [3:0]   r_en;
  logic         a_en, g_en, ir_en;

  assign op    = ir[5:4];
  assign x     = ir[3:2];
  assign y     = ir[1:0];
  assign dbg_q = r[dbg_sel];

  always_comb begin
    state_nxt = state;
    bus       = '0;
    done      = 1'b0;
    r_en      = 4'b0000;
    a_en      = 1'b0;
    g_en      = 1'b0;
    ir_en     = 1'b0;
    case (state)
      T0: begin
        if (run) begin
          ir_en     = 1'b1;
          state_nxt = T1;
        end
      end
      T1: begin
        if (op == OP_MV || op == OP_MVI) begin
          bus       = (op == OP_MV) ? r[y] : din;
          r_en[x]   = 1'b1;
          done      = 1'b1;
          state_nxt = T0;
        end else begin
          bus       = r[x];
          a_en      = 1'b1;
          state_nxt = T2;
        end
      end
      T2: begin
        bus       = r[y];
        g_en      = 1'b1;
        state_nxt = T3;
      end
      T3: begin
        bus       = g;
        r_en[x]   = 1'b1;
        done      = 1'b1;
        state_nxt = T0;
      end
      default: state_nxt = T0;
    endcase
  end

`ifdef PROC_CTRL_FLAGS_EN
  // One extra bit keeps the carry-out of add and the borrow of sub.
  logic [n:0] alu_wide;
  always_comb begin
    alu_wide = (op == OP_SUB) ? ({1'b0, a} - {1'b0, bus}) : ({1'b0, a} + {1'b0, bus});
  end
  assign alu = alu_wide[n-1:0];
`else
  assign alu = (op == OP_SUB) ? (a - bus) : (a + bus);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= T0;
      for (int i = 0; i < 4; i++) r[i] <= '0;
      a  <= '0;
      g  <= '0;
      ir <= '0;
`ifdef PROC_CTRL_FLAGS_EN
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (ir_en) ir <= din[5:0];
      for (int i = 0; i < 4; i++) begin
        if (r_en[i]) r[i] <= bus;
      end
      if (a_en) a <= bus;
      if (g_en) begin
        g <= alu;
`ifdef PROC_CTRL_FLAGS_EN
        zero_flag  <= (alu == '0);
        carry_flag <= alu_wide[n];
`endif
      end
    end
  end

endmodule

// File: tb/tb_simple_proc_ctrl.sv
// tb/tb_simple_proc_ctrl.sv - directed plus random instruction checks of simple_proc_ctrl against a register-level model
module tb_simple_proc_ctrl;
  localparam int N    = 8;
  localparam int MASK = (1 << N) - 1;

  logic         clk = 1'b0;
  logic         rst, run, done;
  logic [N-1:0] din, bus, dbg_q;
  logic [1:0]   dbg_sel;
`ifdef PROC_CTRL_FLAGS_EN
  logic         zero_flag, carry_flag;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int m_r[4];
  int m_z = 0;
  int m_c = 0;

  always #10 clk = ~clk;

  simple_proc_ctrl #(.n(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .din        (din),
    .bus        (bus),
    .done       (done),
    .dbg_sel    (dbg_sel),
    .dbg_q      (dbg_q)
`ifdef PROC_CTRL_FLAGS_EN
    ,
    .zero_flag  (zero_flag),
    .carry_flag (carry_flag)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      chk($sformatf("%s_r%0d", tag, i), dbg_q, m_r[i]);
    end
`ifdef PROC_CTRL_FLAGS_EN
    chk({tag, "_zero"}, zero_flag, m_z);
    chk({tag, "_carry"}, carry_flag, m_c);
`endif
  endtask

  // Runs one instruction from its T0 fetch cycle, checking bus/done every cycle.
  task automatic exec(input int op, input int x, input int y, input int imm, input bit rand_run);
    int    exp_bus[$];
    int    res;
    string tag;
    tag = $sformatf("op%0d_x%0d_y%0d", op, x, y);
    res = 0;
    case (op)
      0: exp_bus = '{m_r[y]};
      1: exp_bus = '{imm & MASK};
      2: begin res = (m_r[x] + m_r[y]) & MASK; exp_bus = '{m_r[x], m_r[y], res}; end
      default: begin res = (m_r[x] - m_r[y]) & MASK; exp_bus = '{m_r[x], m_r[y], res}; end
    endcase

    @(negedge clk);
    run = 1'b1;
    din = N'($urandom);
    din[5:0] = {2'(op), 2'(x), 2'(y)};
    #1;
    chk({tag, "_t0_bus"}, bus, 0);
    chk({tag, "_t0_done"}, done, 0);
    check_regs({tag, "_pre"});

    foreach (exp_bus[k]) begin
      @(negedge clk);
      run = rand_run ? 1'($urandom) : 1'b0;
      din = (op == 1 && k == 0) ? N'(imm) : N'($urandom);
      #1;
      chk($sformatf("%s_c%0d_bus", tag, k + 1), bus, exp_bus[k]);
      chk($sformatf("%s_c%0d_done", tag, k + 1), done, (k == exp_bus.size() - 1) ? 1 : 0);
    end

    case (op)
      0: m_r[x] = m_r[y];
      1: m_r[x] = imm & MASK;
      2: begin m_c = (m_r[x] + m_r[y] > MASK) ? 1 : 0; m_z = (res == 0) ? 1 : 0; m_r[x] = res; end
      default: begin m_c = (m_r[x] < m_r[y]) ? 1 : 0; m_z = (res == 0) ? 1 : 0; m_r[x] = res; end
    endcase
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; din = '0; dbg_sel = 2'd0;
    for (int i = 0; i < 4; i++) m_r[i] = 0;

    repeat (2) @(negedge clk);
    #1;
    chk("reset_bus", bus, 0);
    chk("reset_done", done, 0);
    check_regs("reset");
    rst = 1'b0;

    exec(1, 0, 0, 'h2A, 1'b0);
    exec(0, 1, 0, 0, 1'b0);
    exec(1, 0, 0, 'hFF, 1'b0);
    exec(1, 1, 0, 'h01, 1'b0);
    exec(2, 0, 1, 0, 1'b0);
    exec(1, 2, 0, 'h05, 1'b0);
    exec(1, 3, 0, 'h07, 1'b0);
    exec(3, 2, 3, 0, 1'b0);
    exec(0, 1, 1, 0, 1'b0);
    exec(1, 2, 0, 'h33, 1'b0);
    exec(2, 2, 2, 0, 1'b0);
    exec(3, 2, 2, 0, 1'b0);

    for (int t = 0; t < 60; t++) begin
      exec(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
           int'($urandom_range(0, MASK)), 1'b1);
    end

    // Reset lands at the end of T2 of add R0,R1.
    exec(1, 0, 0, 'h11, 1'b0);
    exec(1, 1, 0, 'h22, 1'b0);
    @(negedge clk);
    run = 1'b1;
    din = N'(6'b10_00_01);
    #1;
    check_regs("pre_abort");
    @(negedge clk);
    run = 1'b0;
    #1;
    chk("abort_t1_bus", bus, m_r[0]);
    @(negedge clk);
    rst = 1'b1;
    run = 1'b1;
    #1;
    chk("abort_t2_bus", bus, m_r[1]);
    chk("abort_t2_done", done, 0);
    for (int i = 0; i < 4; i++) m_r[i] = 0;
    m_z = 0;
    m_c = 0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("abort_rst%0d_bus", c), bus, 0);
      chk($sformatf("abort_rst%0d_done", c), done, 0);
      check_regs($sformatf("abort_rst%0d", c));
    end
    rst = 1'b0;
    run = 1'b0;
    @(negedge clk);
    #1;
    chk("post_abort_idle_bus", bus, 0);
    chk("post_abort_idle_done", done, 0);
    exec(1, 3, 0, 'h5A, 1'b0);
    exec(2, 3, 3, 0, 1'b0);
    @(negedge clk);
    run = 1'b0;
    #1;
    check_regs("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
